// File: rtl/ibuf_pkg.sv
// Shared definitions for the ping/pong input activation buffer: bank state,
// default geometry and small index helpers.
package ibuf_pkg;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

  localparam int DWIDTH_DEF = 12;
  localparam int DEPTH_DEF  = 1024;
  localparam int NRD_DEF    = 4;

  // LSB position of channel ch inside a flat bus of width-bit fields.
  function automatic int ch_lsb(input int ch, input int width);
    return ch * width;
  endfunction

  // Only a non-power-of-2 depth can see addresses beyond the array.
  function automatic logic addr_in_range(input int addr, input int depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/ibuf_bank_ram.sv
// Simple dual-port bank RAM: one write port, one registered read port.
// Out-of-range writes are dropped and out-of-range reads return zero.
module ibuf_bank_ram
  import ibuf_pkg::*;
#(
  parameter  int DWIDTH = DWIDTH_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; only the output register is cleared.
  always_ff @(posedge clk) begin
    if (we && addr_in_range(int'(waddr), DEPTH)) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= addr_in_range(int'(raddr), DEPTH) ? mem[raddr] : '0;
    end
  end

endmodule

// File: rtl/ibuf_pingpong.sv
// Ping/pong input activation buffer: the loader fills one bank while NRD readers drain
// the other; banks swap via commit/release. Define IBUF_ZERO_FLAG_EN to add rd_zero.
module ibuf_pingpong
  import ibuf_pkg::*;
#(
  parameter  int DWIDTH = DWIDTH_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  parameter  int NRD    = NRD_DEF,
  localparam int AWIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [AWIDTH-1:0]     wr_addr,
  input  logic [DWIDTH-1:0]     wr_data,
  input  logic                  wr_commit,
  output logic                  wr_ready,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*AWIDTH-1:0] rd_addr,
  output logic [NRD*DWIDTH-1:0] rd_data,
  output logic [NRD-1:0]        rd_valid,
  input  logic                  rd_release,
  output logic                  rd_avail,
  output logic                  err_ovf
`ifdef IBUF_ZERO_FLAG_EN
  ,
  output logic [NRD-1:0]        rd_zero
`endif
);

  bank_state_e       bank_st  [2];
  bank_state_e       bank_nxt [2];
  logic              wsel, rsel, wsel_nxt, rsel_nxt;
  logic              wr_fire, commit_fire, rel_fire;
  logic [NRD-1:0]    rd_acc;
  logic [NRD-1:0]    rd_bank_q;
  logic [DWIDTH-1:0] ram_q [2][NRD];

  assign wr_fire     = wr_en && wr_ready;
  assign commit_fire = wr_commit && wr_ready;
  assign rel_fire    = rd_release && rd_avail;
  assign rd_acc      = rd_en & {NRD{rd_avail}};
  assign wsel_nxt    = wsel ^ commit_fire;
  assign rsel_nxt    = rsel ^ rel_fire;

  // A commit needs an empty write bank and a release a full read bank, so both may fire together.
  always_comb begin
    // NOTE: start from the current state so every path assigns bank_nxt and no latch is inferred.
    bank_nxt = bank_st;
    if (commit_fire) bank_nxt[wsel] = BANK_FULL;
    if (rel_fire)    bank_nxt[rsel] = BANK_EMPTY;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st[0] <= BANK_EMPTY;
      bank_st[1] <= BANK_EMPTY;
      wsel       <= 1'b0;
      rsel       <= 1'b0;
      wr_ready   <= 1'b1;
      rd_avail   <= 1'b0;
      err_ovf    <= 1'b0;
      rd_valid   <= '0;
      rd_bank_q  <= '0;
    end else begin
      bank_st[0] <= bank_nxt[0];
      bank_st[1] <= bank_nxt[1];
      wsel       <= wsel_nxt;
      rsel       <= rsel_nxt;
      wr_ready   <= (bank_nxt[wsel_nxt] == BANK_EMPTY);
      rd_avail   <= (bank_nxt[rsel_nxt] == BANK_FULL);
      if ((wr_en || wr_commit) && !wr_ready) err_ovf <= 1'b1;
      rd_valid   <= rd_acc;
      // Remember which bank each channel last read so rd_data holds across a release.
      rd_bank_q  <= (rd_bank_q & ~rd_acc) | (rd_acc & {NRD{rsel}});
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    for (genvar c = 0; c < NRD; c++) begin : g_ch
      ibuf_bank_ram #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
      ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_fire && (wsel == 1'(b))),
        .waddr (wr_addr),
        .wdata (wr_data),
        .re    (rd_acc[c] && (rsel == 1'(b))),
        .raddr (rd_addr[ch_lsb(c, AWIDTH) +: AWIDTH]),
        .rdata (ram_q[b][c])
      );
    end
  end

  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NRD; c++) begin
      rd_data[ch_lsb(c, DWIDTH) +: DWIDTH] = rd_bank_q[c] ? ram_q[1][c] : ram_q[0][c];
    end
  end

`ifdef IBUF_ZERO_FLAG_EN
  // Decoded only from registered rd_valid/rd_data, so it carries no path from the inputs.
  always_comb begin
    rd_zero = '0;
    for (int c = 0; c < NRD; c++) begin
      rd_zero[c] = rd_valid[c] && (rd_data[ch_lsb(c, DWIDTH) +: DWIDTH] == '0);
    end
  end
`endif

endmodule

// File: tb/tb_ibuf_pingpong.sv
// Self-checking bench for ibuf_pingpong: directed vector table plus hand-written
// sequences for fill/commit, overflow, ping-pong swaps and async reset.
module tb_ibuf_pingpong;

  localparam int DW  = 12;
  localparam int DP  = 1024;
  localparam int NRD = 4;
  localparam int AW  = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              wr_commit;
  logic              wr_ready;
  logic [NRD-1:0]    rd_en;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_valid;
  logic              rd_release;
  logic              rd_avail;
  logic              err_ovf;
`ifdef IBUF_ZERO_FLAG_EN
  logic [NRD-1:0]    rd_zero;
`endif

  int n_checks = 0;
  int n_errors = 0;

  ibuf_pingpong #(.DWIDTH(DW), .DEPTH(DP), .NRD(NRD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_commit  (wr_commit),
    .wr_ready   (wr_ready),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_release (rd_release),
    .rd_avail   (rd_avail),
    .err_ovf    (err_ovf)
`ifdef IBUF_ZERO_FLAG_EN
    ,
    .rd_zero    (rd_zero)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  rd_en;
    logic        rd_release;
    logic [9:0]  raddr;
    logic        wr_en;
    logic        wr_commit;
    logic [9:0]  waddr;
    logic [11:0] wdata;
    logic [3:0]  exp_valid;
    logic        exp_avail;
    logic        exp_ready;
    logic        exp_err;
    logic [11:0] exp_data;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    wr_commit  = 1'b0;
    rd_en      = '0;
    rd_addr    = '0;
    rd_release = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_wr_ready"}, 64'(wr_ready), 64'd1);
    check({tag, "_rd_avail"}, 64'(rd_avail), 64'd0);
    check({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
    check({tag, "_err_ovf"},  64'(err_ovf),  64'd0);
    check({tag, "_rd_data"},  64'(rd_data),  64'd0);
  endtask

  task automatic wr(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = a[AW-1:0];
    wr_data = d[DW-1:0];
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic commit();
    wr_commit = 1'b1;
    tick();
    wr_commit = 1'b0;
  endtask

  task automatic release_bank();
    rd_release = 1'b1;
    tick();
    rd_release = 1'b0;
  endtask

  task automatic read4(input string tag, input int a0, input int a1, input int a2, input int a3,
                       input int e0, input int e1, input int e2, input int e3);
    int e [4];
    e = '{e0, e1, e2, e3};
    rd_en   = 4'hF;
    rd_addr = {a3[AW-1:0], a2[AW-1:0], a1[AW-1:0], a0[AW-1:0]};
    tick();
    rd_en = '0;
    check({tag, "_valid"}, 64'(rd_valid), 64'hF);
    for (int c = 0; c < NRD; c++) begin
      check($sformatf("%s_ch%0d", tag, c), 64'(rd_data[c*DW +: DW]), 64'(e[c][DW-1:0]));
    end
  endtask

  function automatic int pat(input int r, input int a);
    return (r * 37 + a * 5 + 1) & 12'hFFF;
  endfunction

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    // Test 1: fill bank 0 with data=addr, commit, multi-channel read incl. identical addresses.
    do_reset();
    check_reset_state("t1_reset");
    for (int a = 0; a < DP; a++) wr(a, a);
    check("t1_avail_before_commit", 64'(rd_avail), 64'd0);
    commit();
    check("t1_wr_ready", 64'(wr_ready), 64'd1);
    check("t1_rd_avail", 64'(rd_avail), 64'd1);
    read4("t1_read", 5, 5, 1023, 0, 5, 5, 1023, 0);

    // Test 2: both banks full, overflow write dropped, release exposes original contents.
    for (int a = 0; a < 8; a++) wr(a, 12'h800 | a);
    commit();
    check("t2_wr_ready_full", 64'(wr_ready), 64'd0);
    check("t2_err_before", 64'(err_ovf), 64'd0);
    wr(5, 12'h123);
    check("t2_err_after", 64'(err_ovf), 64'd1);
    read4("t2_bank0", 5, 6, 7, 0, 5, 6, 7, 0);
    release_bank();
    check("t2_ready_after_rel", 64'(wr_ready), 64'd1);
    check("t2_avail_after_rel", 64'(rd_avail), 64'd1);
    read4("t2_bank1", 5, 0, 7, 5, 12'h805, 12'h800, 12'h807, 12'h805);

    // Test 3: eight ping-pong rounds with commit and release in the same cycle.
    do_reset();
    for (int a = 0; a < 16; a++) wr(a, pat(0, a));
    commit();
    for (int r = 1; r <= 8; r++) begin
      for (int a = 0; a < 16; a++) wr(a, pat(r, a));
      for (int a = 0; a < 16; a += 4) begin
        read4($sformatf("t3_r%0d_a%0d", r - 1, a), a, a + 1, a + 2, a + 3,
              pat(r - 1, a), pat(r - 1, a + 1), pat(r - 1, a + 2), pat(r - 1, a + 3));
      end
      wr_commit  = 1'b1;
      rd_release = 1'b1;
      tick();
      wr_commit  = 1'b0;
      rd_release = 1'b0;
      check($sformatf("t3_r%0d_ready", r), 64'(wr_ready), 64'd1);
      check($sformatf("t3_r%0d_avail", r), 64'(rd_avail), 64'd1);
    end
    for (int a = 0; a < 16; a += 4) begin
      read4($sformatf("t3_r8_a%0d", a), a, a + 1, a + 2, a + 3,
            pat(8, a), pat(8, a + 1), pat(8, a + 2), pat(8, a + 3));
    end
    check("t3_err", 64'(err_ovf), 64'd0);

    // Test 4: reads and releases with no committed bank, driven from the vector table.
    do_reset();
    wr(3, 12'h3C3);
    commit();
    read4("t4_setup", 3, 3, 3, 3, 12'h3C3, 12'h3C3, 12'h3C3, 12'h3C3);
    release_bank();
    check("t4_avail_empty", 64'(rd_avail), 64'd0);
    vecs[0] = '{4'hF, 1'b0, 10'd3, 1'b0, 1'b0, 10'd0, 12'h000, 4'h0, 1'b0, 1'b1, 1'b0, 12'h3C3};
    vecs[1] = '{4'h0, 1'b1, 10'd3, 1'b0, 1'b0, 10'd0, 12'h000, 4'h0, 1'b0, 1'b1, 1'b0, 12'h3C3};
    vecs[2] = '{4'hF, 1'b1, 10'd3, 1'b0, 1'b0, 10'd0, 12'h000, 4'h0, 1'b0, 1'b1, 1'b0, 12'h3C3};
    vecs[3] = '{4'h5, 1'b0, 10'd3, 1'b0, 1'b0, 10'd0, 12'h000, 4'h0, 1'b0, 1'b1, 1'b0, 12'h3C3};
    vecs[4] = '{4'h0, 1'b0, 10'd0, 1'b1, 1'b0, 10'd9, 12'h0AA, 4'h0, 1'b0, 1'b1, 1'b0, 12'h3C3};
    vecs[5] = '{4'h0, 1'b0, 10'd0, 1'b0, 1'b1, 10'd0, 12'h000, 4'h0, 1'b1, 1'b1, 1'b0, 12'h3C3};
    vecs[6] = '{4'hF, 1'b0, 10'd9, 1'b0, 1'b0, 10'd0, 12'h000, 4'hF, 1'b1, 1'b1, 1'b0, 12'h0AA};
    vecs[7] = '{4'h0, 1'b0, 10'd9, 1'b0, 1'b0, 10'd0, 12'h000, 4'h0, 1'b1, 1'b1, 1'b0, 12'h0AA};
    vecs[8] = '{4'hF, 1'b1, 10'd9, 1'b0, 1'b0, 10'd0, 12'h000, 4'hF, 1'b0, 1'b1, 1'b0, 12'h0AA};
    vecs[9] = '{4'hF, 1'b0, 10'd3, 1'b0, 1'b0, 10'd0, 12'h000, 4'h0, 1'b0, 1'b1, 1'b0, 12'h0AA};
    for (int i = 0; i < 10; i++) begin
      rd_en      = vecs[i].rd_en;
      rd_release = vecs[i].rd_release;
      rd_addr    = {NRD{vecs[i].raddr}};
      wr_en      = vecs[i].wr_en;
      wr_commit  = vecs[i].wr_commit;
      wr_addr    = vecs[i].waddr;
      wr_data    = vecs[i].wdata;
      tick();
      check($sformatf("t4_v%0d_valid", i), 64'(rd_valid), 64'(vecs[i].exp_valid));
      check($sformatf("t4_v%0d_avail", i), 64'(rd_avail), 64'(vecs[i].exp_avail));
      check($sformatf("t4_v%0d_ready", i), 64'(wr_ready), 64'(vecs[i].exp_ready));
      check($sformatf("t4_v%0d_err", i),   64'(err_ovf),  64'(vecs[i].exp_err));
      check($sformatf("t4_v%0d_data", i),  64'(rd_data),  64'({NRD{vecs[i].exp_data}}));
    end
    idle_inputs();

    // Test 5a: async reset mid-drain with both banks full and err_ovf set.
    do_reset();
    wr(0, 12'h111);
    commit();
    wr(0, 12'h222);
    commit();
    wr(1, 12'h333);
    check("t5_err_set", 64'(err_ovf), 64'd1);
    rd_en   = 4'hF;
    rd_addr = '0;
    tick();
    check("t5_valid_pre", 64'(rd_valid), 64'hF);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("t5_drain");
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_avail_post", 64'(rd_avail), 64'd0);

    // Test 5b: async reset mid-fill while a committed bank is readable.
    wr(0, 12'h444);
    commit();
    check("t5_avail_mid", 64'(rd_avail), 64'd1);
    wr_en   = 1'b1;
    wr_addr = 10'd2;
    wr_data = 12'h555;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("t5_fill");
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_ready_post", 64'(wr_ready), 64'd1);

`ifdef IBUF_ZERO_FLAG_EN
    // Test 6: zero flag aligned with rd_valid.
    do_reset();
    check("t6_zero_reset", 64'(rd_zero), 64'd0);
    wr(0, 0);
    wr(1, 7);
    wr(2, 0);
    commit();
    read4("t6_read", 0, 1, 2, 1, 0, 7, 0, 7);
    check("t6_zero", 64'(rd_zero), 64'b0101);
    tick();
    check("t6_zero_idle", 64'(rd_zero), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
